serial_inc_arbiter: RTL
=======================

SERIAL_INC_ARBITER -- requirements
Module: serial_inc_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset: 0 = reset asserted.
REQ-004 req0, req1  input  1 each  SHALL be the increment requests from requester 0 and requester 1; each is held high until its grant.
REQ-005 data0, data1  input  WIDTH each  SHALL be the operands; each is sampled only on the edge its request is accepted.
REQ-006 gnt0, gnt1  output  1 each  SHALL be one-cycle acceptance pulses.
REQ-007 ha_a, ha_b  output  1 each  SHALL drive the shared external half adder's a and b inputs.
REQ-008 ha_sum, ha_cout  input  1 each  SHALL be the shared half adder's sum and carry outputs (combinational from ha_a, ha_b).
REQ-009 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-010 result  output  WIDTH  SHALL be the incremented operand.
REQ-011 result_id  output  1  SHALL identify the served requester (0 or 1).
REQ-012 overflow  output  1  SHALL be the final carry out of the increment.
REQ-013 result_valid  output  1  SHALL be a one-cycle pulse marking result, result_id and overflow as valid.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE; transitions are IDLE->RUN on acceptance, RUN->DONE after WIDTH RUN cycles, DONE->IDLE unconditionally.
REQ-015 In IDLE, at an edge where req0|req1 is high, the block SHALL accept exactly one request, load that requester's data into the operand shift register, set carry=1 and bit_cnt=0, and record the requester in last_id.
REQ-016 Arbitration SHALL be round-robin.
  - Only one requester high: that requester is granted.
  - Both high: the requester that is not last_id is granted.
  - last_id resets to 1, so requester 0 wins the first tie.
REQ-017 gntN SHALL be registered, high for exactly the one cycle after the acceptance edge, and never asserted outside that cycle.
REQ-018 Requests seen in RUN or DONE SHALL be ignored, with no grant; a held request is arbitrated at the next IDLE edge.
REQ-019 In RUN, the datapath SHALL behave as follows:
  - ha_a = operand shift register bit 0; ha_b = carry.
  - Each edge: ha_sum shifts into the result register at the MSB (LSB-first serial add), the operand shifts right by one, carry <= ha_cout, and bit_cnt increments.
REQ-020 When bit_cnt reaches WIDTH-1 in RUN, the next edge SHALL enter DONE, so RUN lasts exactly WIDTH cycles.
REQ-021 ha_a and ha_b SHALL be 0 in IDLE and DONE.
REQ-022 In DONE, result_valid SHALL be high for one cycle with:
  - result = (operand + 1) mod 2^WIDTH;
  - overflow = final carry (1 only when the operand is all ones);
  - result_id = last_id.
REQ-023 Latency SHALL be WIDTH+1 cycles from the gnt cycle to the result_valid cycle; back-to-back throughput SHALL be one operation per WIDTH+2 cycles.
REQ-024 result, result_id and overflow SHALL hold their values from the last DONE until the next DONE.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH)) bits or wider and SHALL never wrap during RUN.

Reset
REQ-026 While reset=0, the block SHALL be in IDLE with the following values: last_id=1; carry=0; bit_cnt, operand and result registers = 0; all outputs = 0.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation immediately, with no result_valid and no grant; after reset deasserts, the first request is handled as a fresh acceptance.

Verification (WIDTH=8)
REQ-028 req0=1, data0=0x00 after reset -> gnt0 pulse, then result_valid 9 cycles later with result=0x01, overflow=0, result_id=0.
REQ-029 req1=1, data1=0xFF -> result=0x00, overflow=1, result_id=1; data0=0x7F -> result=0x80, overflow=0 (full carry chain).
REQ-030 req0 and req1 raised on the same edge, data0=0x10, data1=0x20 -> gnt0 first, result 0x11 with id 0; then gnt1 10 cycles after gnt0, result 0x21 with id 1.
REQ-031 req0 and req1 both held high for 4 operations -> grants alternate 0,1,0,1, with gnt pulses exactly 10 cycles apart.
REQ-032 reset driven low 3 cycles into RUN -> all outputs 0 immediately, no result_valid ever appears for that operation, and a subsequent req0 with data0=0x05 yields 0x06.
REQ-033 Every RUN cycle -> ha_b matches the expected ripple carry and ha_a matches the operand bit; in IDLE and DONE, ha_a=ha_b=0.

Source files
------------

// File: rtl/serial_inc_arbiter.sv
// serial_inc_arbiter: round-robin arbiter for two requesters feeding an
// LSB-first serial incrementer built around one shared external half adder.
module serial_inc_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ha_a,
    output logic             ha_b,
    input  logic             ha_sum,
    input  logic             ha_cout,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_id,
    output logic             overflow,
    output logic             result_valid
);
    // one spare bit so the counter can step past WIDTH-1 without wrapping
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d, acc_q, acc_d, result_q, result_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic carry_q, carry_d, last_id_q, last_id_d;
    logic gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic valid_q, valid_d, id_q, id_d, ovf_q, ovf_d;
    logic pick1, run;
    assign run          = state_q == RUN;
    assign ha_a         = run & op_q[0];
    assign ha_b         = run & carry_q;
    assign busy         = state_q != IDLE;
    assign gnt0         = gnt0_q;
    assign gnt1         = gnt1_q;
    assign result       = result_q;
    assign result_id    = id_q;
    assign overflow     = ovf_q;
    assign result_valid = valid_q;
    always_comb begin
        pick1     = req1 & (~req0 | ~last_id_q);
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        last_id_d = last_id_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        valid_d   = 1'b0;
        result_d  = result_q;
        id_d      = id_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: if (req0 | req1) begin
                state_d   = RUN;
                op_d      = pick1 ? data1 : data0;
                carry_d   = 1'b1;
                cnt_d     = '0;
                last_id_d = pick1;
                gnt0_d    = ~pick1;
                gnt1_d    = pick1;
            end
            RUN: begin
                acc_d   = {ha_sum, acc_q[WIDTH-1:1]};
                op_d    = op_q >> 1;
                carry_d = ha_cout;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : RUN;
            end
            DONE: begin
                state_d  = IDLE;
                valid_d  = 1'b1;
                result_d = acc_q;
                ovf_d    = carry_q;
                id_d     = last_id_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            last_id_q <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            id_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            last_id_q <= last_id_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            id_q      <= id_d;
            ovf_q     <= ovf_d;
        end
    end
endmodule
